imem_loader: RTL and testbench
==============================

# imem_loader

Instruction-memory and boot-load stage sitting directly upstream of the single-cycle CPU. Accepts a program as a little-endian byte stream over a valid/ready port, packs it into a word-addressed instruction RAM, and holds the CPU in reset until the load completes. In run mode it serves the CPU's `iaddr` with combinational `idata`, returning NOP for unloaded or out-of-range words.

## Interface
- `DEPTH_LOG2`, default 8: log2 of the instruction-word capacity (256 words).
- `RELEASE_CYCLES`, default 2: cycles `cpu_reset` is held after the load ends.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  one clock; reset is asynchronous and active-low.
- `ld_valid`  in  1  load byte valid.
- `ld_ready`  out  1  loader accepts a byte.
- `ld_byte`  in  8  load data byte.
- `ld_last`  in  1  qualifies the final byte of the program.
- `reload`  in  1  single-cycle pulse; restarts loading from `RUN`.
- `iaddr`  in  32  CPU fetch byte address.
- `idata`  out  32  instruction word, combinational from `iaddr`.
- `cpu_reset`  out  1  active-high reset to the CPU.
- `load_done`  out  1  high in `RUN`.
- `word_count`  out  `DEPTH_LOG2+1`  number of words written.
- `err`  out  1  sticky overflow/checksum error.

## Operation
- States: `IDLE`, `LOAD`, `CHECK` (macro only), `HALT` (macro only), `RELEASE`, `RUN`.
- Reset values: state `IDLE`, `cpu_reset=1`, `load_done=0`, `err=0`, `word_count=0`, byte lane 0, `ld_ready=1`.
- `ld_ready=1` in `IDLE`/`LOAD`/`CHECK`, else 0. A transfer is `ld_valid && ld_ready`.
- `IDLE`→`LOAD` on the first transfer; that byte is consumed.
- Bytes fill lanes 0..3, with lane 0 in bits [7:0]. The word is written to `mem[word_count]` on the cycle lane 3 is accepted, then `word_count` increments.
- A transfer with `ld_last`:
  - If lanes are partial, it writes the word with unfilled lanes zero.
  - It then moves to `RELEASE` (or `CHECK` with the macro).
  - `ld_last` on a first-lane-0 byte still writes a word.
- Overflow: a word write when `word_count==2^DEPTH_LOG2` is dropped and sets `err`. Loading continues until `ld_last`, and the run still proceeds.
- `RELEASE` lasts exactly `RELEASE_CYCLES` cycles, then the block moves to `RUN`. `cpu_reset=1` in every state except `RUN`.
- Read path: index = `iaddr[DEPTH_LOG2+1:2]`; `iaddr[1:0]` is ignored.
  - `idata = 32'h00000013` if `iaddr[31:DEPTH_LOG2+2]!=0` or index ≥ `word_count`.
  - Otherwise `idata = mem[index]`.
- `reload` in `RUN` (or `HALT`): next state `IDLE`; `word_count`, lanes and `err` are cleared; `cpu_reset=1` from the next cycle. RAM contents are not cleared.
- `reload` in `LOAD`/`CHECK` restarts the same way. It has priority over a simultaneous transfer, and that byte is not accepted.
- Async reset mid-load: all state is cleared immediately; partial words are lost.

## Timing
- A word write is visible on `idata` the cycle after the accepting edge.
- Final transfer at edge N: state is `RELEASE` after N. `cpu_reset` falls after edge N+`RELEASE_CYCLES`, with `load_done` rising together.
- One byte per cycle sustained, with no bubbles at word boundaries.

## Configuration
- Macro `IMEM_CHECKSUM_EN`.
- Defined:
  - The block keeps a 32-bit wrapping sum of all written words, including the padded last word.
  - After `ld_last` it enters `CHECK` and accepts exactly 4 little-endian checksum bytes; `ld_last` is ignored there.
  - On match it goes to `RELEASE`. On mismatch it sets `err` and enters `HALT`, where `cpu_reset=1`, `ld_ready=0`, and only `reload` or reset exits.
- Undefined: no `CHECK`/`HALT` states and no sum register. `LOAD`→`RELEASE` directly.

## Structure
- Package `imem_pkg`: state enum, `NOP_INSN=32'h00000013`, `BYTES_PER_WORD=4`.
- Sub-module `imem_ram`: `2^DEPTH_LOG2`×32, one synchronous write port, one asynchronous read port, no reset.

## Test plan
- Load bytes `13 00 00 00 B7 0F 00 00` with `ld_last` on the 8th byte. Expect:
  - `word_count=2`, `idata@0=0x00000013`, `idata@4=0x00000FB7`, `idata@8=0x00000013`.
  - `cpu_reset` falls 2 cycles after the last transfer.
- Load 5 bytes `AA BB CC DD EE` with `ld_last` → `idata@0=0xDDCCBBAA`, `idata@4=0x000000EE`, `word_count=2`.
- With `DEPTH_LOG2=2`, load 20 bytes → `err=1`, `word_count=4`, `idata@0x10=0x00000013`, `load_done=1`.
- `reload` pulse in `RUN`, with `ld_valid` held high → next cycle `cpu_reset=1`, `word_count=0`, `err=0`. The first byte is accepted one cycle later.
- `IMEM_CHECKSUM_EN` with words `0x00000013` and `0x00000FB7`:
  - Checksum bytes `CA 0F 00 00` → `RUN`.
  - Checksum bytes `00 00 00 00` → `HALT`, `err=1`, `cpu_reset` stays 1.
- Drop `reset` low after 6 bytes → outputs return to reset values asynchronously. Reload 4 bytes → `word_count=1`.

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg -- shared types and constants for the instruction-memory loader.
//   state_t        : loader FSM state encoding
//   NOP_INSN       : instruction returned for unloaded / out-of-range fetches
//   BYTES_PER_WORD : load-stream bytes packed into one instruction word
package imem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    HALT,
    RELEASE,
    RUN
  } state_t;

  localparam logic [31:0] NOP_INSN       = 32'h00000013;
  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_ram.sv
// imem_ram -- 2^DEPTH_LOG2 x 32 instruction RAM, no reset.
//   clk     : write clock (rising edge)
//   i_we    : write enable
//   i_waddr : write word address
//   i_wdata : write data
//   i_raddr : asynchronous read word address
//   o_rdata : asynchronous read data
module imem_ram #(
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [31:0]           i_wdata,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [31:0]           o_rdata
);

  logic [31:0] r_mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/imem_loader.sv
// imem_loader -- boot loader and instruction memory in front of the CPU.
// Packs a little-endian byte stream into word RAM, holds the CPU in reset
// until loading completes, then serves combinational fetches.
// Optional feature macro: IMEM_CHECKSUM_EN (4-byte checksum after ld_last).
//   clk        : clock, rising edge
//   reset      : asynchronous, active-low
//   ld_valid   : load byte valid        ld_ready  : loader accepts a byte
//   ld_byte    : load data byte         ld_last   : final program byte
//   reload     : restart loading from RUN/HALT/LOAD/CHECK
//   iaddr      : CPU fetch byte address idata     : fetched word (comb)
//   cpu_reset  : active-high CPU reset  load_done : high in RUN
//   word_count : words written          err       : sticky overflow/checksum error
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2     = 8,
  parameter int unsigned RELEASE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [7:0]          ld_byte,
  input  logic                ld_last,
  input  logic                reload,
  input  logic [31:0]         iaddr,
  output logic [31:0]         idata,
  output logic                cpu_reset,
  output logic                load_done,
  output logic [DEPTH_LOG2:0] word_count,
  output logic                err
);

  localparam int unsigned     RC_W      = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST   = RC_W'(RELEASE_CYCLES - 1);
  localparam logic [1:0]      LANE_LAST = 2'(BYTES_PER_WORD - 1);

`ifdef IMEM_CHECKSUM_EN
  localparam state_t LOAD_EXIT = CHECK;
`else
  localparam state_t LOAD_EXIT = RELEASE;
`endif

  state_t                r_state;
  state_t                w_next;
  logic [1:0]            r_lane;
  logic [23:0]           r_buf;
  logic [DEPTH_LOG2:0]   r_word_count;
  logic                  r_err;
  logic [RC_W-1:0]       r_rel_cnt;

  logic                  w_reload;
  logic                  w_xfer;
  logic                  w_load_ph;
  logic                  w_word_end;
  logic                  w_wr_word;
  logic                  w_full;
  logic                  w_we;
  logic [31:0]           w_word;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_oob;
  logic [31:0]           w_rdata;
  logic [1:0]            w_unused_iaddr;

`ifdef IMEM_CHECKSUM_EN
  logic [31:0]           r_sum;
  logic                  w_sum_done;
  logic                  w_sum_ok;
`endif

  // reload wins over a simultaneous transfer; IDLE/RELEASE ignore it
  assign w_reload   = reload && (r_state inside {LOAD, CHECK, HALT, RUN});
  assign w_xfer     = ld_valid && ld_ready && !w_reload;
  assign w_load_ph  = (r_state == IDLE) || (r_state == LOAD);
  assign w_word_end = (r_lane == LANE_LAST);
  // r_buf holds zeros above the current lane, so OR-ing in the new byte
  // gives a zero-padded word when ld_last lands on a partial word
  assign w_word     = {8'h00, r_buf} | ({24'h000000, ld_byte} << {r_lane, 3'b000});
  assign w_wr_word  = w_xfer && w_load_ph && (w_word_end || ld_last);
  assign w_full     = r_word_count[DEPTH_LOG2];
  assign w_we       = w_wr_word && !w_full;

`ifdef IMEM_CHECKSUM_EN
  // checksum bytes reuse the lane/buffer packer
  assign w_sum_done = w_xfer && (r_state == CHECK) && w_word_end;
  assign w_sum_ok   = (w_word == r_sum);
`endif

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_xfer) w_next = ld_last ? LOAD_EXIT : LOAD;
      end
      LOAD: begin
        if (w_reload)             w_next = IDLE;
        else if (w_xfer && ld_last) w_next = LOAD_EXIT;
      end
`ifdef IMEM_CHECKSUM_EN
      CHECK: begin
        if (w_reload)        w_next = IDLE;
        else if (w_sum_done) w_next = w_sum_ok ? RELEASE : HALT;
      end
      HALT: begin
        if (w_reload) w_next = IDLE;
      end
`endif
      RELEASE: begin
        if (r_rel_cnt == RC_LAST) w_next = RUN;
      end
      RUN: begin
        if (w_reload) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ld_ready  = 1'b0;
    cpu_reset = 1'b1;
    load_done = 1'b0;
    case (r_state)
      IDLE, LOAD: ld_ready = 1'b1;
`ifdef IMEM_CHECKSUM_EN
      CHECK:      ld_ready = 1'b1;
`endif
      RUN: begin
        cpu_reset = 1'b0;
        load_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: byte packer, word counter, error flag, release timer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lane       <= '0;
      r_buf        <= '0;
      r_word_count <= '0;
      r_err        <= 1'b0;
      r_rel_cnt    <= '0;
`ifdef IMEM_CHECKSUM_EN
      r_sum        <= '0;
`endif
    end else begin
      if (w_reload) begin
        r_lane       <= '0;
        r_buf        <= '0;
        r_word_count <= '0;
        r_err        <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
        r_sum        <= '0;
`endif
      end else if (w_xfer) begin
        if (w_word_end || (w_load_ph && ld_last)) begin
          r_lane <= '0;
          r_buf  <= '0;
        end else begin
          r_lane <= r_lane + 1'b1;
          r_buf  <= w_word[23:0];
        end
        if (w_wr_word) begin
          if (w_full) r_err        <= 1'b1;
          else        r_word_count <= r_word_count + 1'b1;
`ifdef IMEM_CHECKSUM_EN
          r_sum <= r_sum + w_word;
`endif
        end
`ifdef IMEM_CHECKSUM_EN
        if (w_sum_done && !w_sum_ok) r_err <= 1'b1;
`endif
      end

      if (r_state == RELEASE) r_rel_cnt <= r_rel_cnt + 1'b1;
      else                    r_rel_cnt <= '0;
    end
  end

  assign word_count = r_word_count;
  assign err        = r_err;

  // Read path: byte offset is ignored; anything beyond the loaded region
  // or the RAM's address range reads as NOP
  assign w_unused_iaddr = iaddr[1:0];
  assign w_idx          = iaddr[DEPTH_LOG2+1:2];
  assign w_oob          = (|iaddr[31:DEPTH_LOG2+2]) || ({1'b0, w_idx} >= r_word_count);
  assign idata          = w_oob ? NOP_INSN : w_rdata;

  imem_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(r_word_count[DEPTH_LOG2-1:0]),
    .i_wdata(w_word),
    .i_raddr(w_idx),
    .o_rdata(w_rdata)
  );

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader -- directed bench for imem_loader. Two instances share
// stimulus: A uses defaults (256 words), B uses DEPTH_LOG2=2 (4 words).
// Expected instruction words are pushed as bytes are driven and popped
// against instance A's fetch port once the load finishes.
module tb_imem_loader;
  import imem_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ld_valid = 1'b0;
  logic        ld_last = 1'b0;
  logic        reload = 1'b0;
  logic [7:0]  ld_byte = '0;
  logic [31:0] iaddr = '0;

  logic        a_ready, a_cpu_reset, a_done, a_err;
  logic [31:0] a_idata;
  logic [8:0]  a_wc;
  logic        b_ready, b_cpu_reset, b_done, b_err;
  logic [31:0] b_idata;
  logic [2:0]  b_wc;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [31:0] m_word, m_sum;
  int unsigned m_lane, m_cnt;

  always #5 clk = ~clk;

  imem_loader u_a (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(a_ready),
    .ld_byte(ld_byte), .ld_last(ld_last), .reload(reload), .iaddr(iaddr),
    .idata(a_idata), .cpu_reset(a_cpu_reset), .load_done(a_done),
    .word_count(a_wc), .err(a_err)
  );

  imem_loader #(.DEPTH_LOG2(2)) u_b (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(b_ready),
    .ld_byte(ld_byte), .ld_last(ld_last), .reload(reload), .iaddr(iaddr),
    .idata(b_idata), .cpu_reset(b_cpu_reset), .load_done(b_done),
    .word_count(b_wc), .err(b_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_word = '0;
    m_sum  = '0;
    m_lane = 0;
    m_cnt  = 0;
    sb.delete();
  endtask

  // Drive one load byte and record the word it completes (if any)
  task automatic xfer(input logic [7:0] b, input bit last);
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
    m_word   = m_word | (32'(b) << (8 * m_lane));
    if (m_lane == 3 || last) begin
      sb.push_back('{addr: m_cnt * 4, data: m_word});
      m_sum  = m_sum + m_word;
      m_cnt++;
      m_word = '0;
      m_lane = 0;
    end else begin
      m_lane++;
    end
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic send_sum(input logic [31:0] s);
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1;
      ld_byte  = s[8*i +: 8];
      ld_last  = (i == 0);
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // Called right after the ld_last transfer; checks the release timing
  task automatic end_load();
`ifdef IMEM_CHECKSUM_EN
    chk("check_ready", 32'(a_ready), 32'd1);
    send_sum(m_sum);
`endif
    chk("rel0_cpu_reset", 32'(a_cpu_reset), 32'd1);
    chk("rel0_ready", 32'(a_ready), 32'd0);
    tick();
    chk("rel1_cpu_reset", 32'(a_cpu_reset), 32'd1);
    chk("rel1_done", 32'(a_done), 32'd0);
    tick();
    chk("run_cpu_reset", 32'(a_cpu_reset), 32'd0);
    chk("run_done", 32'(a_done), 32'd1);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      iaddr = e.addr;
      #1;
      chk($sformatf("idata@%0h", e.addr), a_idata, e.data);
    end
    iaddr = m_cnt * 4;
    #1;
    chk("idata_past_end", a_idata, NOP_INSN);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
    model_clear();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cpu_reset"}, 32'(a_cpu_reset), 32'd1);
    chk({tag, "_done"}, 32'(a_done), 32'd0);
    chk({tag, "_err"}, 32'(a_err), 32'd0);
    chk({tag, "_wc"}, 32'(a_wc), 32'd0);
    chk({tag, "_ready"}, 32'(a_ready), 32'd1);
    chk({tag, "_b_err"}, 32'(b_err), 32'd0);
    chk({tag, "_b_done"}, 32'(b_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e3;
    model_clear();
    #2 reset = 1'b0;
    #1 chk_reset_vals("por");
    tick();
    tick();
    reset = 1'b1;

    // Two-word program
    xfer(8'h13, 0); xfer(8'h00, 0); xfer(8'h00, 0); xfer(8'h00, 0);
    iaddr = 32'h0;
    #1;
    chk("t1_wc_word0", 32'(a_wc), 32'd1);
    chk("t1_idata0_early", a_idata, 32'h00000013);
    xfer(8'hB7, 0); xfer(8'h0F, 0); xfer(8'h00, 0); xfer(8'h00, 1);
    end_load();
    chk("t1_wc", 32'(a_wc), 32'd2);
    chk("t1_b_wc", 32'(b_wc), 32'd2);
    iaddr = 32'h5;
    #1;
    chk("t1_idata5_lsb_ignored", a_idata, 32'h00000FB7);
    iaddr = 32'h404;
    #1;
    chk("t1_idata_hi_bits", a_idata, NOP_INSN);
    drain();

    // reload with ld_valid held high, then a 5-byte program
    ld_valid = 1'b1;
    ld_byte  = 8'hAA;
    reload   = 1'b1;
    tick();
    reload = 1'b0;
    model_clear();
    chk("rl_cpu_reset", 32'(a_cpu_reset), 32'd1);
    chk("rl_wc", 32'(a_wc), 32'd0);
    chk("rl_err", 32'(a_err), 32'd0);
    chk("rl_ready", 32'(a_ready), 32'd1);
    xfer(8'hAA, 0); xfer(8'hBB, 0); xfer(8'hCC, 0);
    chk("rl_wc_3bytes", 32'(a_wc), 32'd0);
    xfer(8'hDD, 0);
    chk("rl_wc_4bytes", 32'(a_wc), 32'd1);
    iaddr = 32'h4;
    #1;
    chk("rl_stale_word_hidden", a_idata, NOP_INSN);
    xfer(8'hEE, 1);
    end_load();
    chk("t2_wc", 32'(a_wc), 32'd2);
    drain();

    // 20 bytes: overflows B (4 words), fits A
    do_reload();
    for (int i = 0; i < 20; i++) begin
      xfer(8'(i * 7 + 3), i == 19);
    end
    e3 = sb[3];
    end_load();
    chk("ov_b_err", 32'(b_err), 32'd1);
    chk("ov_b_wc", 32'(b_wc), 32'd4);
    chk("ov_b_done", 32'(b_done), 32'd1);
    chk("ov_a_err", 32'(a_err), 32'd0);
    chk("ov_a_wc", 32'(a_wc), 32'd5);
    iaddr = 32'h10;
    #1;
    chk("ov_b_idata10", b_idata, NOP_INSN);
    iaddr = 32'hC;
    #1;
    chk("ov_b_idataC", b_idata, e3.data);
    drain();

    // async reset from RUN
    #1 reset = 1'b0;
    #1 chk_reset_vals("rst_run");
    #1 reset = 1'b1;

`ifdef IMEM_CHECKSUM_EN
    // checksum mismatch lands in HALT
    model_clear();
    xfer(8'h13, 0); xfer(8'h00, 0); xfer(8'h00, 0); xfer(8'h00, 0);
    xfer(8'hB7, 0); xfer(8'h0F, 0); xfer(8'h00, 0); xfer(8'h00, 1);
    chk("cs_sum_model", m_sum, 32'h00000FCA);
    send_sum(32'h0);
    chk("halt_ready", 32'(a_ready), 32'd0);
    chk("halt_err", 32'(a_err), 32'd1);
    tick();
    tick();
    chk("halt_cpu_reset", 32'(a_cpu_reset), 32'd1);
    chk("halt_done", 32'(a_done), 32'd0);
    do_reload();
    chk("halt_reload_err", 32'(a_err), 32'd0);
    chk("halt_reload_ready", 32'(a_ready), 32'd1);
`endif

    // async reset mid-load drops the partial program
    model_clear();
    for (int i = 0; i < 6; i++) begin
      xfer(8'(8'h40 + i), 0);
    end
    chk("mid_wc_before", 32'(a_wc), 32'd1);
    #2 reset = 1'b0;
    #1 chk_reset_vals("rst_mid");
    #1 reset = 1'b1;
    model_clear();
    xfer(8'h01, 0); xfer(8'h02, 0); xfer(8'h03, 0); xfer(8'h04, 1);
    end_load();
    chk("post_rst_wc", 32'(a_wc), 32'd1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
